// File: rtl/mic_array_capture_pkg.sv
// Shared types and frame-layout constants for the I2S microphone array capture block.
package mic_array_capture_pkg;

  localparam int unsigned FRAME_SLOTS      = 64;
  localparam int unsigned LEFT_FIRST_SLOT  = 1;
  localparam int unsigned RIGHT_FIRST_SLOT = 33;
  localparam int unsigned SLOT_W           = $clog2(FRAME_SLOTS);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCapture,
    StDone
  } state_e;

  // True when slot lies in [first, first+len).
  function automatic logic slot_in(input logic [SLOT_W-1:0] slot, input int unsigned first,
                                   input int unsigned len);
    return (32'(slot) >= first) && (32'(slot) < first + len);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running I2S master timing: sck, ws, slot index and one-clk rise/fall strobes.
module i2s_clkgen
  import mic_array_capture_pkg::*;
#(
  parameter int unsigned SCK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              sck,
  output logic              ws,
  output logic [SLOT_W-1:0] slot,
  output logic              rise,
  output logic              fall
);

  localparam int unsigned DivW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [DivW-1:0]   div_q;
  logic              sck_q;
  logic [SLOT_W-1:0] slot_q;
  logic              tick;

  assign tick = (div_q == DivW'(SCK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      sck_q  <= 1'b0;
      slot_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      sck_q <= ~sck_q;
      // Slot advances as sck falls.
      if (sck_q) slot_q <= slot_q + SLOT_W'(1);
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign sck  = sck_q;
  assign ws   = slot_q[SLOT_W-1];
  assign slot = slot_q;
  assign rise = tick & ~sck_q;
  assign fall = tick & sck_q;

endmodule

// File: rtl/mic_array_capture.sv
// Captures frames from NUM_MICS stereo I2S lines into a frame buffer (one-shot or continuous).
// Define MIC_ARRAY_CAPTURE_ROUND_EN to round half-up with positive saturation instead of truncating.
module mic_array_capture
  import mic_array_capture_pkg::*;
#(
  parameter int unsigned NUM_MICS = 2,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned SCK_DIV  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          go,
  input  logic                          mode_cont,
  input  logic                          abort,
  input  logic [NUM_MICS-1:0]           sd,
  output logic                          sck,
  output logic                          ws,
  input  logic [$clog2(2*NUM_MICS)-1:0] rd_ch,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr,
  output logic [OUT_W-1:0]              rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          wrap
);

  localparam int unsigned NumCh = 2 * NUM_MICS;
  localparam int unsigned ChW   = $clog2(NumCh);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned WordW = NumCh * OUT_W;

  logic [SLOT_W-1:0] slot;
  logic              sck_rise, sck_fall, frame_end;

  i2s_clkgen #(
    .SCK_DIV(SCK_DIV)
  ) u_clkgen (
    .clk  (clk),
    .rst_n(rst_n),
    .sck  (sck),
    .ws   (ws),
    .slot (slot),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  assign frame_end = sck_fall && (slot == SLOT_W'(FRAME_SLOTS - 1));

  // Deserialisers run continuously; the FSM only decides which frames are stored.
  logic [SAMPLE_W-1:0] left_q  [NUM_MICS];
  logic [SAMPLE_W-1:0] right_q [NUM_MICS];
  logic                in_left, in_right;

  assign in_left  = slot_in(slot, LEFT_FIRST_SLOT, SAMPLE_W);
  assign in_right = slot_in(slot, RIGHT_FIRST_SLOT, SAMPLE_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_MICS); k++) begin
        left_q[k]  <= '0;
        right_q[k] <= '0;
      end
    end else if (sck_rise) begin
      for (int k = 0; k < int'(NUM_MICS); k++) begin
        if (in_left)  left_q[k]  <= {left_q[k][SAMPLE_W-2:0], sd[k]};
        if (in_right) right_q[k] <= {right_q[k][SAMPLE_W-2:0], sd[k]};
      end
    end
  end

  function automatic logic [OUT_W-1:0] to_out(input logic [SAMPLE_W-1:0] s);
`ifdef MIC_ARRAY_CAPTURE_ROUND_EN
    localparam int unsigned RndBit = (SAMPLE_W > OUT_W) ? SAMPLE_W - OUT_W - 1 : 0;
    logic [OUT_W:0] top;
    logic           rnd;
    // Adding the first discarded bit to the truncated value is round-half-up.
    rnd = (SAMPLE_W > OUT_W) ? s[RndBit] : 1'b0;
    top = {s[SAMPLE_W-1], s[SAMPLE_W-1 -: OUT_W]} + {{OUT_W{1'b0}}, rnd};
    if (top[OUT_W] != top[OUT_W-1]) return {1'b0, {(OUT_W - 1){1'b1}}};
    return top[OUT_W-1:0];
`else
    return s[SAMPLE_W-1 -: OUT_W];
`endif
  endfunction

  logic [WordW-1:0] wr_word;

  always_comb begin
    wr_word = '0;
    for (int k = 0; k < int'(NUM_MICS); k++) begin
      wr_word[(2*k)*OUT_W +: OUT_W]   = to_out(left_q[k]);
      wr_word[(2*k+1)*OUT_W +: OUT_W] = to_out(right_q[k]);
    end
  end

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             cont_q, cont_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic             wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cont_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      cont_q  <= cont_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    cont_d  = cont_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (go) begin
            state_d = StArm;
            done_d  = 1'b0;
            cont_d  = mode_cont;
          end
        end
        StArm: begin
          if (frame_end) begin
            state_d = StCapture;
            ptr_d   = '0;
          end
        end
        StCapture: begin
          if (frame_end) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + AddrW'(1);
            if (ptr_q == AddrW'(DEPTH - 1)) begin
              done_d = 1'b1;
              if (cont_q) wrap_d = 1'b1;
              else        state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Per-address valid bits let a reset clear the buffer without resetting the array itself.
  logic [WordW-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [WordW-1:0] rd_word;
  logic [OUT_W-1:0] rd_lane;
  logic [OUT_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= wr_word;
  end

  assign rd_word = mem_q[rd_addr];

  always_comb begin
    rd_lane = '0;
    if (valid_q[rd_addr] && ({1'b0, rd_ch} < (ChW + 1)'(NumCh))) begin
      rd_lane = rd_word[32'(rd_ch) * OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) valid_q[ptr_q] <= 1'b1;
      rd_data_q <= rd_lane;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = (state_q == StArm) || (state_q == StCapture);
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: doc/mic_array_capture.md
MIC_ARRAY_CAPTURE -- requirements
Module: mic_array_capture

Interface
REQ-001 SHALL have parameter NUM_MICS, default 2, meaning stereo I2S data lines (2*NUM_MICS channels), range 1..4.
REQ-002 SHALL have parameter SAMPLE_W, default 24, meaning bits captured per slot, range 8..31.
REQ-003 SHALL have parameter OUT_W, default 16, meaning stored bits per sample, OUT_W <= SAMPLE_W.
REQ-004 SHALL have parameter DEPTH, default 1024, meaning frames per buffer, power of two.
REQ-005 SHALL have parameter SCK_DIV, default 8, meaning clk cycles per SCK half-period, >= 2.
REQ-006 clk  in  1  system clock; reset rst_n, synchronous, active-low; clock clk.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 go  in  1  one-clk start pulse; mode_cont  in  1  continuous mode, sampled on go.
REQ-009 abort  in  1  return to IDLE; sd  in  NUM_MICS  serial data, one bit per mic pair.
REQ-010 sck  out  1  I2S bit clock; ws  out  1  word select, 0 = left.
REQ-011 rd_ch  in  $clog2(2*NUM_MICS)  channel select (2k left, 2k+1 right of pair k); rd_addr  in  $clog2(DEPTH)  frame index.
REQ-012 rd_data  out  OUT_W  stored sample; busy  out  1  ARM or CAPTURE; done  out  1  buffer complete; wrap  out  1  one-clk pulse per continuous-mode wrap.

Function
REQ-013 sck SHALL toggle every SCK_DIV clk cycles whenever out of reset, independent of capture state.
REQ-014 A frame SHALL be 64 SCK periods; slot index 0..63 SHALL advance on each sck falling edge; ws = slot[5].
REQ-015 On each sck rising edge, slots 1..SAMPLE_W SHALL shift sd MSB-first into left registers, slots 33..32+SAMPLE_W into right registers.
REQ-016 FSM states: IDLE, ARM, CAPTURE, DONE.
REQ-017 IDLE/DONE + go -> ARM, clears done, latches mode_cont; go in ARM/CAPTURE SHALL be ignored.
REQ-018 ARM -> CAPTURE on the clk where slot wraps 63 -> 0; write pointer = 0.
REQ-019 In CAPTURE, at slot 63 falling edge, all 2*NUM_MICS samples SHALL be written in one clk to address = write pointer; pointer += 1.
REQ-020 Stored sample SHALL be the upper OUT_W bits of the SAMPLE_W two's-complement value (truncation).
REQ-021 One-shot: after write at DEPTH-1 -> DONE, done = 1 from the next clk until go, abort or reset.
REQ-022 Continuous: after write at DEPTH-1 pointer wraps to 0, wrap pulses one clk, state stays CAPTURE, done = 1 (sticky).
REQ-023 abort SHALL force IDLE next clk from any state, clear done, discard the partial frame; abort wins over simultaneous go.
REQ-024 rd_data SHALL be valid one clk after rd_ch/rd_addr; reads SHALL be permitted in any state; an unwritten location returns 0.
REQ-025 A read at the address written in the same clk SHALL return the old data.

Reset
REQ-026 Under rst_n = 0: state IDLE, sck 0, ws 0, slot 0, busy 0, done 0, wrap 0, rd_data 0, pointer 0, shift registers 0.
REQ-027 Reset mid-CAPTURE SHALL abandon the capture; buffer contents SHALL read 0 after reset.

Configuration
REQ-028 Macro MIC_ARRAY_CAPTURE_ROUND_EN defined: stored sample = upper OUT_W bits rounded half-up, saturated to +max on positive overflow.
REQ-029 Macro absent: plain truncation per REQ-020, no rounding logic present.

Structure
REQ-030 Package mic_array_capture_pkg SHALL hold the state enum, FRAME_SLOTS = 64, LEFT_FIRST_SLOT = 1, RIGHT_FIRST_SLOT = 33.
REQ-031 Sub-module i2s_clkgen SHALL generate sck, ws, slot index, and the rise/fall strobes in the clk domain.
REQ-032 The sample buffer SHALL be one DEPTH x (2*NUM_MICS*OUT_W) memory with a registered read; rd_ch selects the lane.

Verification
REQ-033 Defaults, one-shot, mic model drives left = 0x123456 and right = 0xABCDEF on both pairs -> after 1024 frames done = 1; rd_ch 0..3 at any address read 0x1234, 0xABCD, 0x1234, 0xABCD.
REQ-034 Continuous, DEPTH = 8, ramp samples -> wrap pulses every 8 frames; address 0 holds frame 8 after the first wrap.
REQ-035 go mid-CAPTURE, then abort together with go -> go ignored, state IDLE, done 0, busy 0 next clk.
REQ-036 With ROUND_EN, left = 0x7FFF80 -> stored 0x7FFF (saturated); left = 0x000080 -> 0x0001; without ROUND_EN -> 0x7FFF and 0x0000.
REQ-037 rst_n low for 1 clk at frame 500 of a capture -> all outputs at reset values, rd_data 0 at address 10, new go then completes normally.
REQ-038 NUM_MICS = 4, SAMPLE_W = 16, OUT_W = 16 -> 8 distinct per-channel constants read back bit-exact.
